tmds_bitslip_ctrl: RTL
======================

TMDS_BITSLIP_CTRL -- requirements
Module: tmds_bitslip_ctrl

Interface
REQ-001 Parameter SEARCH_WINDOW, 1024: cycles spent looking for a token run at one slip position.
REQ-002 Parameter MATCH_RUN, 8: consecutive control tokens that declare alignment.
REQ-003 Parameter SETTLE_CYCLES, 4: idle cycles after each bit_slip pulse.
REQ-004 Parameter LOSS_TIMEOUT, 65535: token-free cycles in LOCKED that declare loss of lock.
REQ-005 Port list:
- clk_1x_in, input, 1: divided pixel clock. This is the only clock.
- reset_n_in, input, 1: reset. Synchronous, active-low.
- clk_locked_in, input, 1: PLL/MMCM lock. Its input synchronizer lives outside this block.
- deser_data_in, input, 10: parallel word from the deserializer.
- bit_slip_out, output, 1: single-cycle slip request to the deserializer.
- aligned_out, output, 1: high while in LOCKED.
- slip_count_out, output, 4: current slip position, 0..9.
- search_fail_out, output, 1: sticky; set when all 10 slip positions fail.

Function
REQ-006 Control tokens SHALL be exactly 10'h354, 10'h0AB, 10'h154 and 10'h2AB, compared against all 10 bits of deser_data_in.
REQ-007 FSM states SHALL be IDLE, SEARCH, SLIP, SETTLE and LOCKED. All outputs SHALL be registered.
REQ-008 IDLE: leave for SEARCH on the first cycle clk_locked_in=1. On entry to SEARCH, clear the window counter and the run counter.
REQ-009 SEARCH behaviour:
- Each cycle, increment the window counter.
- A token increments the run counter; a non-token clears it to 0.
- When the run counter reaches MATCH_RUN, go to LOCKED on the next cycle.
- Otherwise, when the window counter reaches SEARCH_WINDOW-1, go to SLIP.
- If both happen in the same cycle, the match wins.
REQ-010 SLIP behaviour:
- Assert bit_slip_out=1 for exactly one cycle.
- Set slip_count_out to (slip_count_out+1) mod 10.
- If slip_count_out wraps from 9 to 0, set search_fail_out.
- Go to SETTLE.
REQ-011 SETTLE: hold for SETTLE_CYCLES cycles with bit_slip_out=0 and the data ignored, then go to SEARCH.
REQ-012 bit_slip_out pulses SHALL be separated by at least SETTLE_CYCLES+SEARCH_WINDOW cycles.
REQ-013 LOCKED behaviour:
- Hold aligned_out=1.
- Clear search_fail_out on entry.
- Keep a 16-bit token-free counter: cleared on any token, incremented otherwise.
- When the counter reaches LOSS_TIMEOUT, go to SEARCH with aligned_out=0 on the next cycle. slip_count_out is retained.
REQ-014 clk_locked_in=0 in any state SHALL force IDLE on the next cycle with these effects:
- bit_slip_out=0 and aligned_out=0.
- All counters cleared except slip_count_out.
- A slip pulse in progress is not extended.
REQ-015 slip_count_out SHALL reflect the total number of slips issued, mod 10, so that it tracks the deserializer's internal slip position.

Reset
REQ-016 When reset_n_in=0 at a clock edge, the block SHALL set the following on that edge:
- state=IDLE.
- bit_slip_out=0, aligned_out=0, slip_count_out=0, search_fail_out=0.
- All internal counters = 0.
REQ-017 Reset SHALL dominate clk_locked_in and every state transition, including a reset asserted during SLIP or SETTLE.

Configuration
REQ-018 With macro TMDS_BITSLIP_STATS_EN defined, the block SHALL add output port slip_total_out [15:0] with this behaviour:
- Counts every bit_slip_out pulse.
- Saturates at 16'hFFFF.
- Cleared only by reset.
REQ-019 Without TMDS_BITSLIP_STATS_EN, slip_total_out and its counter SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-020 Aligned-stream scenario:
- Stimulus: reset, clk_locked_in=1, deser_data_in=10'h354 continuously.
- Required response: aligned_out=1 exactly MATCH_RUN+2 cycles after leaving IDLE; bit_slip_out is never asserted.
- Cycle accounting: one cycle IDLE→SEARCH, MATCH_RUN matching cycles, one cycle to LOCKED.
REQ-021 Rotated-token scenario:
- Stimulus: a stream that shows valid tokens only after 3 slips; the model rotates on each pulse.
- Required response: exactly 3 one-cycle bit_slip_out pulses, each at least SETTLE_CYCLES+SEARCH_WINDOW cycles apart; then slip_count_out=3 and aligned_out=1.
REQ-022 Token-free scenario:
- Stimulus: a random non-token stream for 10×(SEARCH_WINDOW+SETTLE_CYCLES+1)+10 cycles.
- Required response: 10 pulses, slip_count_out back at 0, search_fail_out=1, aligned_out=0.
REQ-023 Loss-of-lock scenario:
- Stimulus: once LOCKED, feed 10'h000 for LOSS_TIMEOUT cycles.
- Required response: aligned_out falls on the next cycle, state=SEARCH, slip_count_out unchanged.
REQ-024 Lock-drop and reset scenario:
- Stimulus: drop clk_locked_in during SETTLE; separately, pull reset_n_in low for one cycle during a bit_slip_out pulse.
- Required response for the lock drop: IDLE on the next cycle, no further slip pulse.
- Required response for the reset: all outputs are 0 on the next cycle.
REQ-025 Stats scenario:
- Stimulus: with TMDS_BITSLIP_STATS_EN defined, run the REQ-022 scenario twice without reset.
- Required response: slip_total_out=20.

Source files
------------

// File: rtl/tmds_bitslip_ctrl.sv
// rtl/tmds_bitslip_ctrl.sv - TMDS word-alignment bit-slip controller (define TMDS_BITSLIP_STATS_EN to add slip_total_out)
module tmds_bitslip_ctrl #(
  parameter int SEARCH_WINDOW = 1024,
  parameter int MATCH_RUN     = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int LOSS_TIMEOUT  = 65535
) (
  input  logic       clk_1x_in,
  input  logic       reset_n_in,
  input  logic       clk_locked_in,
  input  logic [9:0] deser_data_in,
  output logic       bit_slip_out,
  output logic       aligned_out,
  output logic [3:0] slip_count_out,
  output logic       search_fail_out
`ifdef TMDS_BITSLIP_STATS_EN
  ,
  output logic [15:0] slip_total_out
`endif
);

  localparam int WIN_W = $clog2(SEARCH_WINDOW + 1);
  localparam int RUN_W = $clog2(MATCH_RUN + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    SLIP   = 3'd2,
    SETTLE = 3'd3,
    LOCKED = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  logic [WIN_W-1:0] win_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic [SET_W-1:0] settle_cnt;
  logic [15:0]      loss_cnt;

  logic       is_token;
  logic       bit_slip_d;
  logic       aligned_d;
  logic [3:0] slip_count_d;
  logic       search_fail_d;

  // Match the four TMDS control-period symbols on the full 10-bit word
  always_comb begin
    is_token = (deser_data_in == 10'h354) || (deser_data_in == 10'h0AB) ||
               (deser_data_in == 10'h154) || (deser_data_in == 10'h2AB);
  end

  // State register; reset dominates everything
  always_ff @(posedge clk_1x_in) begin
    if (!reset_n_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; losing the clock lock sends every state back to IDLE
  always_comb begin
    next_state = state;
    if (!clk_locked_in) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:   next_state = SEARCH;
        SEARCH: begin
          if (run_cnt == RUN_W'(MATCH_RUN)) begin
            next_state = LOCKED;
          end else if (win_cnt == WIN_W'(SEARCH_WINDOW - 1)) begin
            next_state = SLIP;
          end
        end
        SLIP:   next_state = SETTLE;
        SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
            next_state = SEARCH;
          end
        end
        LOCKED: begin
          if (loss_cnt == 16'(LOSS_TIMEOUT)) begin
            next_state = SEARCH;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Per-state counters, all cleared on any state change so each state starts fresh
  always_ff @(posedge clk_1x_in) begin
    if (!reset_n_in) begin
      win_cnt    <= '0;
      run_cnt    <= '0;
      settle_cnt <= '0;
      loss_cnt   <= '0;
    end else if (next_state != state) begin
      win_cnt    <= '0;
      run_cnt    <= '0;
      settle_cnt <= '0;
      loss_cnt   <= '0;
    end else begin
      case (state)
        SEARCH: begin
          win_cnt <= win_cnt + WIN_W'(1);
          run_cnt <= is_token ? run_cnt + RUN_W'(1) : '0;
        end
        SETTLE: settle_cnt <= settle_cnt + SET_W'(1);
        LOCKED: loss_cnt   <= is_token ? 16'd0 : loss_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  // Output decode from the upcoming state so every output comes straight from a flop
  always_comb begin
    bit_slip_d    = (next_state == SLIP);
    aligned_d     = (next_state == LOCKED);
    slip_count_d  = slip_count_out;
    search_fail_d = search_fail_out;
    if (next_state == SLIP) begin
      if (slip_count_out == 4'd9) begin
        slip_count_d  = 4'd0;
        search_fail_d = 1'b1;
      end else begin
        slip_count_d = slip_count_out + 4'd1;
      end
    end
    if ((next_state == LOCKED) && (state != LOCKED)) begin
      search_fail_d = 1'b0;
    end
  end

  // Output registers; slip position survives lock loss so it keeps tracking the deserializer
  always_ff @(posedge clk_1x_in) begin
    if (!reset_n_in) begin
      bit_slip_out    <= 1'b0;
      aligned_out     <= 1'b0;
      slip_count_out  <= 4'd0;
      search_fail_out <= 1'b0;
    end else begin
      bit_slip_out    <= bit_slip_d;
      aligned_out     <= aligned_d;
      slip_count_out  <= slip_count_d;
      search_fail_out <= search_fail_d;
    end
  end

`ifdef TMDS_BITSLIP_STATS_EN
  // Saturating lifetime count of slip pulses, cleared only by reset
  always_ff @(posedge clk_1x_in) begin
    if (!reset_n_in) begin
      slip_total_out <= 16'd0;
    end else if (bit_slip_d && (slip_total_out != 16'hFFFF)) begin
      slip_total_out <= slip_total_out + 16'd1;
    end
  end
`endif

endmodule
